// File: rtl/gaussian_window_ctrl_if.sv
// Pixel stream bundle for the 3x3 Gaussian window: input side and output side,
// each a valid/ready handshake. The slave modport is the filter's view.
interface gaussian_window_ctrl_if;
  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_valid
  );

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid
  );
endinterface

// File: rtl/gaussian_window_ctrl.sv
// 3x3 Gaussian blur over a raster stream using two line buffers; emits interior pixels only.
// Optional macro GWC_BYPASS_EN adds a bypass input that passes the window centre unfiltered.
module gaussian_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef GWC_BYPASS_EN
  input  logic bypass,
`endif
  gaussian_window_ctrl_if.slave io
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t                 state_q;
  logic [CW-1:0]          col_q;
  logic [RW-1:0]          row_q;
  logic [7:0]             line0_q [IMG_W];
  logic [7:0]             line1_q [IMG_W];
  logic [2:0][2:0][7:0]   win_q;
  logic [2:0][2:0][7:0]   win_d;
  logic [7:0]             out_pixel_q;
  logic                   out_valid_q;
  logic                   done_q;

  logic        in_ready_c;
  logic        accept;
  logic        win_ok;
  logic        last_col;
  logic        last_row;
  logic        at_first_win;
  logic [11:0] sum_c;
  logic [7:0]  filt_c;
  logic [7:0]  result_c;

  assign in_ready_c   = ((state_q == FILL) || (state_q == RUN)) && (!out_valid_q || io.out_ready);
  assign accept       = io.in_valid && in_ready_c;
  assign last_col     = (col_q == CW'(IMG_W - 1));
  assign last_row     = (row_q == RW'(IMG_H - 1));
  assign at_first_win = (row_q == RW'(2)) && (col_q == CW'(2));
  assign win_ok       = (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Row index 0 is the top line, column index 2 is the newest (rightmost) column.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = line0_q[col_q];
    win_d[1][2] = line1_q[col_q];
    win_d[2][2] = io.in_pixel;
  end

  always_comb begin
    sum_c = ({4'd0, win_d[1][1]} << 2)
          + (({4'd0, win_d[0][1]} + {4'd0, win_d[1][0]}
            + {4'd0, win_d[1][2]} + {4'd0, win_d[2][1]}) << 1)
          + {4'd0, win_d[0][0]} + {4'd0, win_d[0][2]}
          + {4'd0, win_d[2][0]} + {4'd0, win_d[2][2]};
    filt_c = 8'(sum_c >> 4);
`ifdef GWC_BYPASS_EN
    result_c = bypass ? win_d[1][1] : filt_c;
`else
    result_c = filt_c;
`endif
  end

  // Line buffers are never reset; every read location is rewritten before it contributes.
  always_ff @(posedge clk) begin
    if (accept) begin
      line0_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= io.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        win_q <= win_d;
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      // accept implies any held result is being consumed this cycle, so no overwrite.
      if (accept && win_ok) begin
        out_pixel_q <= result_c;
        out_valid_q <= 1'b1;
      end else if (io.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (accept && last_col && last_row) state_q <= DRAIN;
          else if (accept && at_first_win)    state_q <= RUN;
        end
        RUN: begin
          if (accept && last_col && last_row) state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_valid_q && io.out_ready) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign io.in_ready  = in_ready_c;
  assign io.out_pixel = out_pixel_q;
  assign io.out_valid = out_valid_q;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Bench for gaussian_window_ctrl on a 4x4 image: randomized handshakes checked against
// a direct 3x3 convolution model of each frame.
module tb_gaussian_window_ctrl;
  localparam int W       = 4;
  localparam int H       = 4;
  localparam int NPIX    = W * H;
  localparam int MAX_CYC = 1000;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;
`ifdef GWC_BYPASS_EN
  logic bypass = 1'b0;
`endif

  gaussian_window_ctrl_if u_if();

  gaussian_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
`ifdef GWC_BYPASS_EN
    .bypass(bypass),
`endif
    .io    (u_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         frame [NPIX];
  logic [7:0] out_q [$];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (!rst && u_if.out_valid && u_if.out_ready) out_q.push_back(u_if.out_pixel);
    if (!rst && done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: weights [1 2 1; 2 4 2; 1 2 1] / 16 over every interior pixel, raster order.
  function automatic void build_expected(input bit centre_only);
    int s;
    exp_q.delete();
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * frame[(r + dr) * W + c + dc];
        exp_q.push_back(centre_only ? 8'(frame[r * W + c]) : 8'(s / 16));
      end
    end
  endfunction

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drive_frame(input int vprob, input int rprob, input int start_at,
                             output int cycles, output bit timed_out);
    int idx = 0;
    int d0;
    d0     = done_cnt;
    cycles = 0;
    do_start();
    while (done_cnt == d0 && cycles < MAX_CYC) begin
      u_if.in_valid  = (idx < NPIX) && ($urandom_range(99) < vprob);
      u_if.in_pixel  = (idx < NPIX) ? 8'(frame[idx]) : 8'd0;
      u_if.out_ready = ($urandom_range(99) < rprob);
      start          = (cycles + 1 == start_at);
      @(negedge clk);
      if (u_if.in_valid && u_if.in_ready) idx++;
      @(posedge clk); #1;
      cycles++;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    start          = 1'b0;
    timed_out      = (done_cnt == d0);
  endtask

  task automatic test_reset();
    u_if.in_valid  = 1'b1;
    u_if.in_pixel  = 8'd77;
    u_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", u_if.in_ready); end
    n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", u_if.out_valid); end
    n_checks++; if (u_if.out_pixel !== 8'd0) begin n_fail++; $display("FAIL reset_out_pixel: got %0d expected 0", u_if.out_pixel); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 0", u_if.in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    u_if.in_valid = 1'b0;
  endtask

  task automatic test_constant_frame();
    int cyc; bit to; int d0;
    foreach (frame[i]) frame[i] = 100;
    out_q.delete();
    d0 = done_cnt;
    drive_frame(100, 100, 0, cyc, to);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (to) begin n_fail++; $display("FAIL const_timeout: got timeout expected done"); end
    n_checks++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL const_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== 8'd100) begin n_fail++; $display("FAIL const_pixel[%0d]: got %0d expected 100", i, out_q[i]); end
    end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL const_done_pulses: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL const_busy_after: got %b expected 0", busy); end
    n_checks++; if (cyc !== NPIX + 2) begin n_fail++; $display("FAIL const_throughput: got %0d cycles expected %0d", cyc, NPIX + 2); end
  endtask

  task automatic test_impulse();
    int cyc; bit to;
    logic [7:0] want [4];
    want = '{8'd63, 8'd31, 8'd31, 8'd15};
    foreach (frame[i]) frame[i] = 0;
    frame[1 * W + 1] = 255;
    out_q.delete();
    drive_frame(70, 70, 0, cyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL impulse_timeout: got timeout expected done"); end
    n_checks++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL impulse_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== want[i]) begin n_fail++; $display("FAIL impulse_pixel[%0d]: got %0d expected %0d", i, out_q[i], want[i]); end
    end
  endtask

  task automatic test_random_frames();
    int cyc; bit to; int d0;
    for (int f = 0; f < 6; f++) begin
      foreach (frame[i]) frame[i] = int'($urandom_range(255));
      build_expected(1'b0);
      out_q.delete();
      d0 = done_cnt;
      drive_frame(int'($urandom_range(40, 100)), int'($urandom_range(40, 100)), 0, cyc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout expected done", f); end
      n_checks++; if (out_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", f, out_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
        n_checks++;
        if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_pixel[%0d]: got %0d expected %0d", f, i, out_q[i], exp_q[i]); end
      end
      n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected 1", f, done_cnt - d0); end
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int cyc = 0;
    int d0;
    int stall_left = 5;
    bit stall_now;
    foreach (frame[i]) frame[i] = int'($urandom_range(255));
    build_expected(1'b0);
    out_q.delete();
    d0 = done_cnt;
    do_start();
    while (done_cnt == d0 && cyc < MAX_CYC) begin
      u_if.in_valid  = (idx < NPIX);
      u_if.in_pixel  = (idx < NPIX) ? 8'(frame[idx]) : 8'd0;
      stall_now      = u_if.out_valid && (stall_left > 0);
      u_if.out_ready = !stall_now;
      @(negedge clk);
      if (stall_now) begin
        n_checks++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", u_if.in_ready); end
        n_checks++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b expected 1", u_if.out_valid); end
        n_checks++; if (u_if.out_pixel !== exp_q[0]) begin n_fail++; $display("FAIL stall_out_pixel: got %0d expected %0d", u_if.out_pixel, exp_q[0]); end
        stall_left--;
      end
      if (u_if.in_valid && u_if.in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    n_checks++; if (stall_left !== 0) begin n_fail++; $display("FAIL stall_cycles: got %0d left expected 0", stall_left); end
    n_checks++; if (out_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_pixel[%0d]: got %0d expected %0d", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int cyc; bit to; int d0;
    foreach (frame[i]) frame[i] = int'($urandom_range(255));
    out_q.delete();
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < 7; k++) begin
      u_if.in_valid  = 1'b1;
      u_if.in_pixel  = 8'(frame[k]);
      u_if.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    u_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0", u_if.out_valid); end
    n_checks++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 0", u_if.in_ready); end
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - d0); end
    n_checks++; if (out_q.size() !== 0) begin n_fail++; $display("FAIL abort_outputs: got %0d expected 0", out_q.size()); end
    foreach (frame[i]) frame[i] = 50;
    drive_frame(100, 100, 0, cyc, to);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (to) begin n_fail++; $display("FAIL abort_timeout: got timeout expected done"); end
    n_checks++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL abort_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== 8'd50) begin n_fail++; $display("FAIL abort_pixel[%0d]: got %0d expected 50", i, out_q[i]); end
    end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL abort_done_after: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_start_ignored();
    int cyc; bit to; int d0;
    foreach (frame[i]) frame[i] = int'($urandom_range(255));
    build_expected(1'b0);
    out_q.delete();
    d0 = done_cnt;
    drive_frame(100, 100, 13, cyc, to);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (to) begin n_fail++; $display("FAIL restart_timeout: got timeout expected done"); end
    n_checks++; if (cyc !== NPIX + 2) begin n_fail++; $display("FAIL restart_cycles: got %0d expected %0d", cyc, NPIX + 2); end
    n_checks++; if (out_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL restart_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_pixel[%0d]: got %0d expected %0d", i, out_q[i], exp_q[i]); end
    end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL restart_done: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    logic [7:0] all_exp [$];
    all_exp.delete();
    out_q.delete();
    for (int f = 0; f < 2; f++) begin
      foreach (frame[i]) frame[i] = int'($urandom_range(255));
      build_expected(1'b0);
      foreach (exp_q[i]) all_exp.push_back(exp_q[i]);
      drive_frame(100, 100, 0, cyc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL b2b%0d_timeout: got timeout expected done", f); end
    end
    n_checks++; if (out_q.size() !== all_exp.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", out_q.size(), all_exp.size()); end
    for (int i = 0; i < all_exp.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== all_exp[i]) begin n_fail++; $display("FAIL b2b_pixel[%0d]: got %0d expected %0d", i, out_q[i], all_exp[i]); end
    end
  endtask

`ifdef GWC_BYPASS_EN
  task automatic test_bypass();
    int cyc; bit to;
    logic [7:0] want [4];
    want = '{8'd5, 8'd6, 8'd9, 8'd10};
    foreach (frame[i]) frame[i] = i;
    out_q.delete();
    bypass = 1'b1;
    drive_frame(100, 100, 0, cyc, to);
    bypass = 1'b0;
    n_checks++; if (to) begin n_fail++; $display("FAIL bypass_timeout: got timeout expected done"); end
    n_checks++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL bypass_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== want[i]) begin n_fail++; $display("FAIL bypass_pixel[%0d]: got %0d expected %0d", i, out_q[i], want[i]); end
    end
  endtask
`endif

  initial begin
    u_if.in_valid  = 1'b0;
    u_if.in_pixel  = 8'd0;
    u_if.out_ready = 1'b1;
    test_reset();
    test_constant_frame();
    test_impulse();
    test_random_frames();
    test_stall();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
`ifdef GWC_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
